// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the shared-adder counter controller.
// Provides the channel count, the counter width, the FSM state type and the adder result type.
package counter_arb_pkg;

    localparam int NCH = 4;
    localparam int CW  = 32;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [CW-1:0] sum;
        logic          wrap;
    } add_res_t;

    function automatic logic [NCH-1:0] onehot4(input logic [1:0] idx);
        logic [NCH-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Request/status bundle between the requesters and the counter controller.
// The master side issues requests; the slave side reports busy, ack, counts and sticky flags.
interface counter_arbiter_if;
    import counter_arb_pkg::*;

    logic [NCH-1:0] req;
    logic [NCH-1:0] dec;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] err;
    logic [CW-1:0]  cnt0;
    logic [CW-1:0]  cnt1;
    logic [CW-1:0]  cnt2;
    logic [CW-1:0]  cnt3;

    modport master (
        output req, dec,
        input  busy, ack, ovf, err, cnt0, cnt1, cnt2, cnt3
    );

    modport slave (
        input  req, dec,
        output busy, ack, ovf, err, cnt0, cnt1, cnt2, cnt3
    );

endinterface

// File: rtl/counter_arbiter_rr.sv
// Four-way round-robin arbiter: first pending channel at or after ptr, wrapping mod 4.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter_4
    import counter_arb_pkg::*;
(
    input  logic [NCH-1:0] pend,
    input  logic [1:0]     ptr,
    output logic           gnt_vld,
    output logic [1:0]     gnt_idx
);

    logic [1:0] idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        idx     = ptr;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr + 2'(k);
            if (!gnt_vld && pend[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Shared-adder counter controller: buffers one inc/dec request per channel, grants the
// single adder round-robin, and writes the result back two cycles after the request.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter logic [CW-1:0] STEP = CW'(1)
) (
    input  logic             clk,
    input  logic             reset,
    counter_arbiter_if.slave bus
);

    state_t         state_q, state_d;
    logic [NCH-1:0] pend_q,  pend_d;
    logic [NCH-1:0] pdec_q,  pdec_d;
    logic [1:0]     ptr_q,   ptr_d;
    logic [1:0]     g_q,     g_d;
    logic           gdec_q,  gdec_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] ovf_q,   ovf_d;
    logic [NCH-1:0] err_q,   err_d;
    logic [NCH-1:0] ack_q,   ack_d;

    logic           gnt_vld;
    logic [1:0]     gnt_idx;
    logic [NCH-1:0] gnt_oh;
    logic [NCH-1:0] exec_sel;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] accept;
    add_res_t       add_res;

    // Decrement is A + ~STEP + 1; a missing carry-out there is a borrow.
    function automatic add_res_t step_add(input logic [CW-1:0] a, input logic d);
        logic [CW:0]   full;
        logic [CW-1:0] b;
        logic          cin;
        add_res_t      res;
        b        = (d == DIR_DEC) ? ~STEP : STEP;
        cin      = (d == DIR_INC) ? 1'b0 : 1'b1;
        full     = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
        res.sum  = full[CW-1:0];
        res.wrap = (d == DIR_DEC) ? ~full[CW] : full[CW];
        return res;
    endfunction

    rr_arbiter_4 u_arb (
        .pend    (pend_q),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: every grant starts (or continues) an EXEC cycle
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = gnt_vld ? EXEC : IDLE;
            EXEC:    state_d = gnt_vld ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        exec_sel = '0;
        if (state_q == EXEC) exec_sel = onehot4(g_q);
    end

    always_comb begin
        gnt_oh = gnt_vld ? onehot4(gnt_idx) : '0;
        busy   = pend_q | exec_sel;
        accept = bus.req & ~busy;
        pend_d = (pend_q & ~gnt_oh) | accept;
        pdec_d = (pdec_q & ~accept) | (bus.dec & accept);
        err_d  = err_q | (bus.req & busy);
        ptr_d  = gnt_vld ? gnt_idx + 2'd1 : ptr_q;
        g_d    = gnt_vld ? gnt_idx : g_q;
        gdec_d = gnt_vld ? pdec_q[gnt_idx] : gdec_q;
    end

    always_comb begin
        add_res = step_add(cnt_q[g_q], gdec_q);
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ack_d   = exec_sel;
        if (state_q == EXEC) begin
            cnt_d[g_q] = add_res.sum;
            ovf_d[g_q] = ovf_q[g_q] | add_res.wrap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            ptr_q  <= '0;
            ovf_q  <= '0;
            err_q  <= '0;
            ack_q  <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            ack_q  <= ack_d;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Direction and EXEC operands are only read while qualified by pend/EXEC
    always_ff @(posedge clk) begin
        pdec_q <= pdec_d;
        g_q    <= g_d;
        gdec_q <= gdec_d;
    end

    assign bus.busy = busy;
    assign bus.ack  = ack_q;
    assign bus.ovf  = ovf_q;
    assign bus.err  = err_q;
    assign bus.cnt0 = cnt_q[0];
    assign bus.cnt1 = cnt_q[1];
    assign bus.cnt2 = cnt_q[2];
    assign bus.cnt3 = cnt_q[3];

endmodule
